spi_target: RTL

- Byte-oriented SPI target (responder) for the far end of the MCU SPI controller's sclk/pico/poci/cs interface.
- Used in the Verilator MCU testbench and reusable as a peripheral model.
- Oversamples the SPI pins in the system clock domain, deserialises pico into bytes and serialises a host-supplied byte onto poci, MSB first.
- Requires clock frequency >= 8x sclk frequency.

---
 rtl/spi_target.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target : byte-oriented SPI target (responder)
//
// Oversamples sclk/pico/cs in the system clock domain, deserialises pico into
// bytes and serialises a host-supplied byte onto poci, MSB first. The system
// clock must run at least 8x faster than sclk.
//
// Parameters:
//   CPOL       - sclk idle level (must match the controller)
//   CPHA       - 0: sample on leading edge, shift on trailing edge
//                1: shift on leading edge, sample on trailing edge
//   DEFAULT_TX - byte shifted out when no tx byte is loaded
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   sclk     in   SPI clock (asynchronous)
//   pico     in   controller-out data (asynchronous)
//   cs       in   chip select, active low (asynchronous)
//   poci     out  target-out data (0 while not selected)
//   rx_data  out  last complete received byte
//   rx_valid out  rx_data holds an unacknowledged byte
//   rx_ack   in   consumes rx_data
//   tx_data  in   next byte to transmit
//   tx_load  in   write strobe for tx_data
//   tx_ready out  tx buffer empty, tx_load accepted
//   overrun  out  one-cycle pulse: byte completed while rx_valid was set
//   busy     out  synchronised cs asserted
//
// Optional feature: define SPI_TARGET_ECHO_EN to send the last received byte
// (instead of DEFAULT_TX) whenever the tx buffer is empty at a load point.
// -----------------------------------------------------------------------------
module spi_target #(
    parameter logic       CPOL       = 1'b0,
    parameter logic       CPHA       = 1'b0,
    parameter logic [7:0] DEFAULT_TX = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       pico,
    input  logic       cs,
    output logic       poci,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       overrun,
    output logic       busy
);

    // Synchroniser stages (meta -> sync) plus one delay stage for edge detect
    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic pico_meta_q, pico_sync_q;
    logic cs_meta_q,   cs_sync_q,   cs_dly_q;

    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q,  overrun_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q,   tx_buf_d;
    logic       tx_ready_q, tx_ready_d;
    logic       poci_q,     poci_d;
    logic       busy_q,     busy_d;
`ifdef SPI_TARGET_ECHO_EN
    logic       rx_seen_q,  rx_seen_d;
`endif

    logic       active_s;
    logic       cs_fall_s;
    logic       sclk_chg_s;
    logic       lead_s;
    logic       trail_s;
    logic       sample_s;
    logic       shift_s;
    logic       byte_done_s;
    logic       load_s;
    logic [7:0] fallback_s;

    assign active_s    = ~cs_sync_q;
    assign cs_fall_s   = cs_dly_q & ~cs_sync_q;
    assign sclk_chg_s  = sclk_sync_q ^ sclk_dly_q;
    assign lead_s      = active_s & sclk_chg_s & (sclk_sync_q != CPOL);
    assign trail_s     = active_s & sclk_chg_s & (sclk_sync_q == CPOL);
    assign sample_s    = (CPHA == 1'b1) ? trail_s : lead_s;
    assign shift_s     = (CPHA == 1'b1) ? lead_s  : trail_s;
    assign byte_done_s = sample_s & (bit_cnt_q == 3'd7);
    // CPHA=0 presents the MSB before the first sample edge, so it loads at cs
    // fall and at byte completion; CPHA=1 loads on the first leading edge.
    assign load_s      = (CPHA == 1'b1) ? (lead_s & (bit_cnt_q == 3'd0))
                                        : (cs_fall_s | byte_done_s);

    // Next-state logic for framing, rx/tx shifting and both handshakes
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
`ifdef SPI_TARGET_ECHO_EN
        rx_seen_d  = rx_seen_q;
`endif

        // Acknowledge first so that a completion in the same cycle wins
        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (!active_s) begin
            // Deselected: any partial byte is dropped
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'h00;
        end else if (sample_s) begin
            rx_shift_d = {rx_shift_q[6:0], pico_sync_q};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d  = 3'd0;
                rx_data_d  = {rx_shift_q[6:0], pico_sync_q};
                rx_valid_d = 1'b1;
                overrun_d  = rx_valid_q & ~rx_ack;
`ifdef SPI_TARGET_ECHO_EN
                rx_seen_d  = 1'b1;
`endif
            end else begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
        end else begin
            bit_cnt_d  = bit_cnt_q;
        end

`ifdef SPI_TARGET_ECHO_EN
        // Uses the _d values so a CPHA=0 load at byte completion echoes the
        // byte that just finished.
        fallback_s = rx_seen_d ? rx_data_d : DEFAULT_TX;
`else
        fallback_s = DEFAULT_TX;
`endif

        if (load_s) begin
            tx_shift_d = tx_ready_q ? fallback_s : tx_buf_q;
            tx_ready_d = 1'b1;
        end else if (shift_s && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else begin
            tx_shift_d = tx_shift_q;
        end

        // A load point in the same cycle frees the buffer for the new byte
        if (tx_load && (tx_ready_q || load_s)) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end else begin
            tx_buf_d   = tx_buf_q;
        end

        // Using tx_shift_d puts a freshly loaded MSB on poci at the load edge
        poci_d = active_s ? tx_shift_d[7] : 1'b0;
        busy_d = active_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_dly_q  <= CPOL;
            pico_meta_q <= 1'b0;
            pico_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_dly_q    <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_shift_q  <= 8'h00;
            tx_buf_q    <= 8'h00;
            tx_ready_q  <= 1'b1;
            poci_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_TARGET_ECHO_EN
            rx_seen_q   <= 1'b0;
`endif
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            pico_meta_q <= pico;
            pico_sync_q <= pico_meta_q;
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            cs_dly_q    <= cs_sync_q;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            poci_q      <= poci_d;
            busy_q      <= busy_d;
`ifdef SPI_TARGET_ECHO_EN
            rx_seen_q   <= rx_seen_d;
`endif
        end
    end

    assign poci     = poci_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule
